fifo_ctrl_dpram: RTL and testbench

Synchronous FIFO controller that wraps the team's dual-port RAM (`dual_port_ram_asyn`) as its storage. Upstream logic pushes words into the block, and the block drives the RAM write port. Pops drive the RAM read port, and the RAM output is returned to the consumer with a valid strobe. The block owns all pointer, occupancy, flag and error logic. The RAM is only storage.

---
 rtl/fifo_ctrl_dpram.sv | 125 ++++++++++++
 tb/tb_fifo_ctrl_dpram.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_ctrl_dpram.sv
// Purpose : synchronous FIFO controller; owns pointers/occupancy/flags/errors, storage is an external dual-port RAM.
// Latency : push visible to pop one cycle after acceptance; pop_data/pop_valid one cycle after an accepted pop.
// Backpres: pushes while full and pops while empty are dropped (sticky overflow/underflow); 1 push + 1 pop per cycle sustained.
//
// Ports:
//   clk, rst              - single clock, asynchronous active-high reset
//   push/push_data        - write request and word
//   pop                   - read request; pop_data/pop_valid return the word one cycle later
//   full/empty/almost_full/count - occupancy status, all from registered state
//   overflow/underflow    - sticky error flags, clr_err clears them (a same-cycle set wins)
//   ram_*                 - write and read ports of the dual-port RAM (read data registered in the RAM)
module fifo_ctrl_dpram #(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDRESS_SIZE  = 3,
    parameter int ADDRESS_DEPTH = 8,   // must equal 2**ADDRESS_SIZE
    parameter int AFULL_LEVEL   = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic [DATA_WIDTH-1:0]   push_data,
    input  logic                    pop,
    output logic [DATA_WIDTH-1:0]   pop_data,
    output logic                    pop_valid,
    output logic                    full,
    output logic                    empty,
    output logic                    almost_full,
    output logic [ADDRESS_SIZE:0]   count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clr_err,
    output logic [DATA_WIDTH-1:0]   ram_wr_data,
    output logic                    ram_we,
    output logic [ADDRESS_SIZE-1:0] ram_wr_addr,
    output logic                    ram_re,
    output logic [ADDRESS_SIZE-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0]   ram_rd_data
);

    localparam logic [ADDRESS_SIZE:0] DEPTH_C = (ADDRESS_SIZE+1)'(ADDRESS_DEPTH);
    localparam logic [ADDRESS_SIZE:0] AFULL_C = (ADDRESS_SIZE+1)'(AFULL_LEVEL);
    localparam logic [ADDRESS_SIZE:0] ONE_C   = (ADDRESS_SIZE+1)'(1);

    // Pointers carry one extra wrap bit; only the low bits address the RAM.
    logic [ADDRESS_SIZE:0] wptr_q, wptr_d;
    logic [ADDRESS_SIZE:0] rptr_q, rptr_d;
    logic [ADDRESS_SIZE:0] count_q, count_d;
    logic                  pop_valid_q, pop_valid_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  push_acc, pop_acc;

    // Flags come straight from the registered count, so no path from push/pop.
    always_comb begin
        full        = (count_q == DEPTH_C);
        empty       = (count_q == '0);
        almost_full = (count_q >= AFULL_C);
    end

    // A push while full is dropped even if a pop frees a slot this cycle (and
    // vice versa), so the RAM never sees a read and write to one address.
    always_comb begin
        push_acc = push & ~full  & ~rst;
        pop_acc  = pop  & ~empty & ~rst;
    end

    always_comb begin
        ram_we      = push_acc;
        ram_wr_addr = wptr_q[ADDRESS_SIZE-1:0];
        ram_wr_data = push_data;
        ram_re      = pop_acc;
        ram_rd_addr = rptr_q[ADDRESS_SIZE-1:0];
        pop_data    = ram_rd_data;
        pop_valid   = pop_valid_q;
        count       = count_q;
        overflow    = overflow_q;
        underflow   = underflow_q;
    end

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        pop_valid_d = pop_acc;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_acc) wptr_d = wptr_q + ONE_C;
        if (pop_acc)  rptr_d = rptr_q + ONE_C;

        // Occupancy is its own register rather than wptr - rptr.
        unique case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        // Clear first so a simultaneous error event wins.
        if (clr_err) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (push & full)  overflow_d  = 1'b1;
        if (pop  & empty) underflow_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            pop_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            pop_valid_q <= pop_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_dpram.sv
// Purpose : directed self-checking bench for fifo_ctrl_dpram with a behavioural dual-port RAM.
// Latency : RAM model registers read data one cycle after ram_re, like the real RAM.
// Backpres: inputs change on the falling edge; registered outputs are sampled there too.
module tb_fifo_ctrl_dpram;

    logic        clk;
    logic        rst;
    logic        push;
    logic [15:0] push_data;
    logic        pop;
    logic [15:0] pop_data;
    logic        pop_valid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic [3:0]  count;
    logic        overflow;
    logic        underflow;
    logic        clr_err;
    logic [15:0] ram_wr_data;
    logic        ram_we;
    logic [2:0]  ram_wr_addr;
    logic        ram_re;
    logic [2:0]  ram_rd_addr;
    logic [15:0] ram_rd_data;

    int checks   = 0;
    int failures = 0;
    int wp       = 0;   // bench-side pointers, counted in accepted operations
    int rp       = 0;

    logic [15:0] mem [0:7];

    fifo_ctrl_dpram #(
        .DATA_WIDTH(16), .ADDRESS_SIZE(3), .ADDRESS_DEPTH(8), .AFULL_LEVEL(6)
    ) dut (
        .clk(clk), .rst(rst), .push(push), .push_data(push_data), .pop(pop),
        .pop_data(pop_data), .pop_valid(pop_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .count(count), .overflow(overflow),
        .underflow(underflow), .clr_err(clr_err), .ram_wr_data(ram_wr_data),
        .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_re(ram_re),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
    );

    // Behavioural dual_port_ram_asyn: write on edge, registered read.
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_wr_addr] <= ram_wr_data;
        if (ram_re) ram_rd_data <= mem[ram_rd_addr];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; push = 1'b0; pop = 1'b0; clr_err = 1'b0; push_data = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // ---------------- async reset mid-cycle ----------------
        push = 1'b1; push_data = 16'h0A00;
        @(negedge clk);
        push_data = 16'h0A01; pop = 1'b1;
        @(negedge clk);
        check("pre_rst_pop_valid", 32'(pop_valid), 32'd1);
        check("pre_rst_pop_data", 32'(pop_data), 32'h0A00);
        check("pre_rst_count", 32'(count), 32'd1);
        push_data = 16'h0A02;
        #1;
        check("pre_rst_ram_we", 32'(ram_we), 32'd1);
        check("pre_rst_ram_re", 32'(ram_re), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_afull", 32'(almost_full), 32'd0);
        check("rst_pop_valid", 32'(pop_valid), 32'd0);
        check("rst_ram_we", 32'(ram_we), 32'd0);
        check("rst_ram_re", 32'(ram_re), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        check("rst_wr_addr", 32'(ram_wr_addr), 32'd0);
        @(negedge clk);
        push = 1'b0; pop = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // ---------------- fill ----------------
        for (int i = 0; i < 8; i++) begin
            check("fill_count", 32'(count), 32'(i));
            check("fill_afull", 32'(almost_full), 32'(i >= 6));
            check("fill_full", 32'(full), 32'd0);
            check("fill_empty", 32'(empty), 32'(i == 0));
            push = 1'b1; push_data = 16'h1000 + 16'(i);
            #1 check("fill_wr_addr", 32'(ram_wr_addr), 32'(wp % 8));
            @(negedge clk);
            wp++;
        end
        check("full_count", 32'(count), 32'd8);
        check("full_flag", 32'(full), 32'd1);
        check("full_afull", 32'(almost_full), 32'd1);
        push_data = 16'hDEAD;
        #1 check("ovf_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        push = 1'b0;
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd8);

        // ---------------- drain ----------------
        for (int i = 0; i < 8; i++) begin
            pop = 1'b1;
            #1 check("drain_ram_re", 32'(ram_re), 32'd1);
            check("drain_rd_addr", 32'(ram_rd_addr), 32'(rp % 8));
            @(negedge clk);
            rp++;
            check("drain_pop_valid", 32'(pop_valid), 32'd1);
            check("drain_pop_data", 32'(pop_data), 32'h1000 + 32'(i));
            check("drain_count", 32'(count), 32'(7 - i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        #1 check("udf_ram_re", 32'(ram_re), 32'd0);
        @(negedge clk);
        pop = 1'b0;
        check("udf_flag", 32'(underflow), 32'd1);
        check("udf_pop_valid", 32'(pop_valid), 32'd0);
        check("udf_ovf_sticky", 32'(overflow), 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_underflow", 32'(underflow), 32'd0);

        // ---------------- simultaneous push/pop ----------------
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_data = 16'h2000 + 16'(i);
            @(negedge clk);
            wp++;
        end
        check("sim_start_count", 32'(count), 32'd4);
        for (int k = 0; k < 5; k++) begin
            push = 1'b1; pop = 1'b1; push_data = 16'h2004 + 16'(k);
            @(negedge clk);
            wp++; rp++;
            check("sim_pop_data", 32'(pop_data), 32'h2000 + 32'(k));
            check("sim_pop_valid", 32'(pop_valid), 32'd1);
            check("sim_count", 32'(count), 32'd4);
        end
        pop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_data = 16'h2009 + 16'(i);
            @(negedge clk);
            wp++;
        end
        check("sim_full", 32'(full), 32'd1);
        // Push+pop on full, with clr_err asserted: push dropped, error set wins.
        push = 1'b1; pop = 1'b1; clr_err = 1'b1; push_data = 16'hBAD0;
        #1 check("fullpp_ram_we", 32'(ram_we), 32'd0);
        check("fullpp_ram_re", 32'(ram_re), 32'd1);
        @(negedge clk);
        rp++;
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;
        check("fullpp_count", 32'(count), 32'd7);
        check("fullpp_overflow", 32'(overflow), 32'd1);
        check("fullpp_pop_data", 32'(pop_data), 32'h2005);
        for (int i = 0; i < 7; i++) begin
            pop = 1'b1;
            @(negedge clk);
            rp++;
            check("sim_drain_data", 32'(pop_data), 32'h2006 + 32'(i));
        end
        pop = 1'b0;
        check("sim_drain_empty", 32'(empty), 32'd1);

        // ---------------- wrap with single occupancy ----------------
        push = 1'b1; push_data = 16'h3000;
        @(negedge clk);
        wp++;
        for (int k = 0; k < 20; k++) begin
            push = 1'b1; pop = 1'b1; push_data = 16'h3001 + 16'(k);
            #1 check("wrap_wr_addr", 32'(ram_wr_addr), 32'(wp % 8));
            check("wrap_rd_addr", 32'(ram_rd_addr), 32'(rp % 8));
            @(negedge clk);
            wp++; rp++;
            check("wrap_pop_data", 32'(pop_data), 32'h3000 + 32'(k));
            check("wrap_count", 32'(count), 32'(wp - rp));
        end
        push = 1'b0; pop = 1'b1;
        @(negedge clk);
        rp++;
        pop = 1'b0;
        check("wrap_last_data", 32'(pop_data), 32'h3014);
        check("wrap_empty", 32'(empty), 32'd1);

        // ---------------- reset during a pop ----------------
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; push_data = 16'h4000 + 16'(i);
            @(negedge clk);
        end
        push = 1'b0;
        check("midrst_count5", 32'(count), 32'd5);
        pop = 1'b1;
        #4 rst = 1'b1;
        @(negedge clk);
        check("midrst_pop_valid", 32'(pop_valid), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        pop = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_pop_valid", 32'(pop_valid), 32'd0);
        push = 1'b1; push_data = 16'hBEEF;
        #1 check("post_rst_wr_addr", 32'(ram_wr_addr), 32'd0);
        @(negedge clk);
        push = 1'b0; pop = 1'b1;
        @(negedge clk);
        pop = 1'b0;
        check("post_rst_pop_valid1", 32'(pop_valid), 32'd1);
        check("post_rst_pop_data", 32'(pop_data), 32'hBEEF);
        @(negedge clk);
        check("post_rst_pop_valid0", 32'(pop_valid), 32'd0);
        check("post_rst_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
